// File: rtl/mux_nch_reg.sv
// Registered N-channel mux with valid/ready output and auto-scan.
// Ports: clk, rst_n, in_data/in_valid, sel, mode, dwell, out_*, sel_err.
module mux_nch_reg #(
  parameter int N = 8,
  parameter int WIDTH = 1,
  parameter int DWELL_W = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  localparam logic [SEL_W:0] N_EXT =
    (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(N-1);

  logic [SEL_W-1:0]   ptr;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   cur;
  logic               cur_ok;
  logic               sel_ok;
  logic [WIDTH-1:0]   cur_data;
  logic               cur_vld;
  logic               stall;
  logic               load;

  // Decoded one-hot pick keeps out-of-range
  // indices (non power-of-two N) harmless.
  always_comb begin
    cur      = mode ? ptr : sel;
    cur_ok   = {1'b0, cur} < N_EXT;
    sel_ok   = {1'b0, sel} < N_EXT;
    cur_data = '0;
    cur_vld  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (cur == SEL_W'(k)) begin
        cur_data = in_data[k*WIDTH +: WIDTH];
        cur_vld  = in_valid[k];
      end
    end
    stall = out_valid & ~out_ready;
    load  = ~stall & cur_ok & cur_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= load;
      if (load) begin
        out_data <= cur_data;
        out_ch   <= cur;
      end
    end
  end

  // Direct mode keeps ptr on sel so a switch
  // to scan starts there with a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      cnt     <= '0;
      sel_err <= 1'b0;
    end else if (!mode) begin
      cnt     <= '0;
      sel_err <= ~sel_ok;
      if (sel_ok)
        ptr <= sel;
    end else begin
      sel_err <= 1'b0;
      if (!stall) begin
        if (cnt == dwell) begin
          cnt <= '0;
          ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
